// File: rtl/mem_lsu.sv
// MIPS memory-access stage: loads, stores and LL/SC over a req/ack data bus.
// Define LLSC_EN to implement LL/SC with LLbit tracking; otherwise LL=LW, SC=SW writing 1.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic        LLbit_i,
  input  logic        wb_LLbit_we,
  input  logic        wb_LLbit_value,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_LLbit_we,
  output logic        mem_LLbit_value,
  output logic        adel,
  output logic        ades,
  output logic        stallreq
);

  localparam int unsigned RegBus = 32;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [RegBus-1:0]   rdata_q;

  logic                is_load, is_store, is_ll, is_sc;
  logic                is_byte, is_half, is_signed;
  logic                misaligned, llbit_eff, sc_fail, bus_op;
  logic [3:0]          sel_c;
  logic [RegBus-1:0]   wdata_c, load_c;
  logic [7:0]          byte_c;
  logic [15:0]         half_c;

  // Opcode decode and access legality
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_ll     = 1'b0;
    is_sc     = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    case (ex_memop)
      OP_LB:   begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      OP_LBU:  begin is_load = 1'b1; is_byte = 1'b1; end
      OP_LH:   begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      OP_LHU:  begin is_load = 1'b1; is_half = 1'b1; end
      OP_LW:   is_load = 1'b1;
      OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:   is_store = 1'b1;
      OP_LL:   begin is_load = 1'b1; is_ll = 1'b1; end
      OP_SC:   begin is_store = 1'b1; is_sc = 1'b1; end
      default: ;
    endcase
    misaligned = is_half ? ex_mem_addr[0]
                         : ((is_load | is_store) & ~is_byte & (ex_mem_addr[1:0] != 2'b00));
    llbit_eff  = wb_LLbit_we ? wb_LLbit_value : LLbit_i;
`ifdef LLSC_EN
    sc_fail    = is_sc & ~llbit_eff;
`else
    sc_fail    = 1'b0;
`endif
    bus_op     = (is_load | is_store) & ~misaligned & ~sc_fail;
  end

`ifndef LLSC_EN
  logic unused_llsc;
  assign unused_llsc = ^{is_ll, llbit_eff};
`endif

  // Big-endian lane selection, store replication and load extension
  always_comb begin
    sel_c   = 4'b1111;
    wdata_c = ex_reg2;
    if (is_byte) begin
      sel_c   = 4'b1000 >> ex_mem_addr[1:0];
      wdata_c = {4{ex_reg2[7:0]}};
    end else if (is_half) begin
      sel_c   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      wdata_c = {2{ex_reg2[15:0]}};
    end
    case (ex_mem_addr[1:0])
      2'b00:   byte_c = rdata_q[31:24];
      2'b01:   byte_c = rdata_q[23:16];
      2'b10:   byte_c = rdata_q[15:8];
      default: byte_c = rdata_q[7:0];
    endcase
    half_c = ex_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    if (is_byte)
      load_c = is_signed ? {{24{byte_c[7]}}, byte_c} : {24'h0, byte_c};
    else if (is_half)
      load_c = is_signed ? {{16{half_c[15]}}, half_c} : {16'h0, half_c};
    else
      load_c = rdata_q;
  end

  // Next-state logic; an ack coinciding with flush retires the transfer outright
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_op && !flush) state_d = REQ;
      REQ: begin
        if (bus_ack)    state_d = flush ? IDLE : DONE;
        else if (flush) state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      DRAIN:   if (bus_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured read data and the registered bus command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rdata_q   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state_q <= state_d;
      bus_req <= (state_d == REQ) || (state_d == DRAIN);
      if (state_q == REQ && bus_ack) rdata_q <= bus_rdata;
      if (state_q == IDLE && state_d == REQ) begin
        bus_we    <= is_store;
        bus_sel   <= sel_c;
        bus_addr  <= {ex_mem_addr[31:2], 2'b00};
        bus_wdata <= is_store ? wdata_c : '0;
      end
    end
  end

  // Write-back fields and pipeline control
  always_comb begin
    mem_wd          = ex_wd;
    mem_wreg        = ex_wreg;
    mem_wdata       = ex_wdata;
    mem_LLbit_we    = 1'b0;
    mem_LLbit_value = 1'b0;
    stallreq        = 1'b0;
    adel            = 1'b0;
    ades            = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_load || is_store) begin
          mem_wreg = 1'b0;
          if (misaligned) begin
            adel = is_load;
            ades = is_store;
          end else if (sc_fail) begin
            mem_wreg  = 1'b1;
            mem_wdata = '0;
          end else begin
            stallreq = ~flush;
          end
        end
      end
      REQ, DRAIN: begin
        stallreq = 1'b1;
        mem_wreg = 1'b0;
      end
      DONE: begin
        if (is_load) begin
          mem_wreg  = ex_wreg;
          mem_wdata = load_c;
        end else if (is_sc) begin
          mem_wreg  = 1'b1;
          mem_wdata = 32'd1;
        end else begin
          mem_wreg  = 1'b0;
          mem_wdata = '0;
        end
`ifdef LLSC_EN
        mem_LLbit_we    = is_ll | is_sc;
        mem_LLbit_value = is_ll;
`endif
      end
      default: ;
    endcase
    if (!rst) begin
      mem_wd          = '0;
      mem_wreg        = 1'b0;
      mem_wdata       = '0;
      mem_LLbit_we    = 1'b0;
      mem_LLbit_value = 1'b0;
      stallreq        = 1'b0;
      adel            = 1'b0;
      ades            = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed ops, a wait-state bus responder and
// decoupled monitors for write-back results and bus transfers.
`timescale 1ns/1ps
module tb_mem_lsu;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
    logic        llwe;
    logic        llval;
    logic        adel;
    logic        ades;
  } res_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } bus_t;

`ifdef LLSC_EN
  localparam logic LLSC = 1'b1;
`else
  localparam logic LLSC = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0, ex_mem_addr = '0, ex_reg2 = '0;
  logic [3:0]  ex_memop = '0;
  logic        LLbit_i = 1'b0, wb_LLbit_we = 1'b0, wb_LLbit_value = 1'b0;
  logic        bus_req, bus_we, bus_ack = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
  logic [3:0]  bus_sel;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_LLbit_we, mem_LLbit_value, adel, ades, stallreq;
  logic [31:0] mem_wdata;

  logic        op_valid = 1'b0;
  logic [31:0] bus_rdata_v = '0;
  int          ack_delay = 0;
  int          tests = 0, fails = 0;

  res_t  res_q[$];
  string res_name_q[$];
  bus_t  bus_q[$];
  string bus_name_q[$];

  mem_lsu dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_memop(ex_memop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .LLbit_i(LLbit_i), .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
    .adel(adel), .ades(ades), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic res_t mk_res(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                  input logic chk, input logic llwe, input logic llval,
                                  input logic ae_l, input logic ae_s);
    res_t r;
    r.wd = wd; r.wreg = wreg; r.wdata = chk ? wdata : 32'h0; r.chk_data = chk;
    r.llwe = llwe; r.llval = llval; r.adel = ae_l; r.ades = ae_s;
    return r;
  endfunction

  function automatic bus_t mk_bus(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic chk);
    bus_t b;
    b.we = we; b.sel = sel; b.addr = addr; b.wdata = chk ? wdata : 32'h0; b.chk_wdata = chk;
    return b;
  endfunction

  // Bus responder: acks after ack_delay wait cycles of bus_req
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (bus_req) begin
        if (cnt == ack_delay) begin bus_ack = 1'b1; bus_rdata = bus_rdata_v; end
        else begin bus_ack = 1'b0; bus_rdata = 32'hA5A5A5A5; end
        cnt++;
      end else begin
        bus_ack = 1'b0; bus_rdata = 32'hA5A5A5A5; cnt = 0;
      end
    end
  end

  // Result monitor: pops whenever the pipeline would advance past this op
  always @(negedge clk) begin : res_mon
    res_t e, g;
    string n;
    if (rst && op_valid && !stallreq) begin
      if (res_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got wd=%0d wreg=%b, expected none", mem_wd, mem_wreg);
      end else begin
        e = res_q.pop_front();
        n = res_name_q.pop_front();
        g.wd = mem_wd; g.wreg = mem_wreg; g.wdata = e.chk_data ? mem_wdata : 32'h0;
        g.chk_data = e.chk_data; g.llwe = mem_LLbit_we; g.llval = mem_LLbit_value;
        g.adel = adel; g.ades = ades;
        check({n, " result"}, 80'(g), 80'(e));
      end
    end
  end

  // Bus monitor: checks each completed transfer
  always @(negedge clk) begin : bus_mon
    bus_t e, g;
    string n;
    if (bus_req && bus_ack) begin
      if (bus_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_bus: got addr=%h we=%b, expected none", bus_addr, bus_we);
      end else begin
        e = bus_q.pop_front();
        n = bus_name_q.pop_front();
        g.we = bus_we; g.sel = bus_sel; g.addr = bus_addr;
        g.wdata = e.chk_wdata ? bus_wdata : 32'h0; g.chk_wdata = e.chk_wdata;
        check({n, " bus"}, 80'(g), 80'(e));
      end
    end
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] exd, input logic [31:0] rd,
                        input int wait_n, input res_t e, input bit has_bus, input bus_t b,
                        input int exp_stall);
    int stalls;
    bit done;
    @(posedge clk); #1;
    ex_memop = op; ex_mem_addr = addr; ex_reg2 = reg2; ex_wdata = exd;
    ex_wd = e.wd; ex_wreg = 1'b1;
    bus_rdata_v = rd; ack_delay = wait_n;
    res_q.push_back(e); res_name_q.push_back(name);
    if (has_bus) begin bus_q.push_back(b); bus_name_q.push_back(name); end
    op_valid = 1'b1;
    stalls = 0; done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!stallreq) done = 1'b1;
      else stalls++;
    end
    check({name, " stall"}, 80'(stalls), 80'(exp_stall));
    @(posedge clk); #1;
    op_valid = 1'b0; ex_memop = 4'd0; ex_wreg = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  stalls;
    bit  done, wreg_seen;
    bus_t nb;
    nb = mk_bus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    // Reset with a live op on the inputs: outputs must be forced low
    ex_memop = 4'd5; ex_mem_addr = 32'h0; ex_wreg = 1'b1; ex_wd = 5'd7;
    ex_wdata = 32'hDEADBEEF; ex_reg2 = 32'hFFFFFFFF;
    repeat (2) @(posedge clk); #1;
    check("reset bus_req", 80'(bus_req), 80'(0));
    check("reset outputs", 80'({mem_wd, mem_wreg, mem_wdata, mem_LLbit_we, mem_LLbit_value,
                                stallreq, adel, ades, bus_we, bus_sel}), 80'(0));
    ex_memop = 4'd0; ex_wreg = 1'b0;
    @(negedge clk); rst = 1'b1;

    run_op("LB", 4'd1, 32'h103, 32'h0, 32'h0BADF00D, 32'h000000F0, 2,
           mk_res(5'd2, 1'b1, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b0, 4'b0001, 32'h100, 32'h0, 1'b0), 4);
    run_op("LBU", 4'd2, 32'h100, 32'h0, 32'h0BADF00D, 32'h80FFFFFF, 0,
           mk_res(5'd3, 1'b1, 32'h00000080, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b0, 4'b1000, 32'h100, 32'h0, 1'b0), 2);
    run_op("LH", 4'd3, 32'h100, 32'h0, 32'h0BADF00D, 32'h80011234, 0,
           mk_res(5'd4, 1'b1, 32'hFFFF8001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b0, 4'b1100, 32'h100, 32'h0, 1'b0), 2);
    run_op("LHU", 4'd4, 32'h102, 32'h0, 32'h0BADF00D, 32'h12348001, 0,
           mk_res(5'd5, 1'b1, 32'h00008001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b0, 4'b0011, 32'h100, 32'h0, 1'b0), 2);
    run_op("LW", 4'd5, 32'h104, 32'h0, 32'h0BADF00D, 32'hDEADBEEF, 1,
           mk_res(5'd6, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b0, 4'b1111, 32'h104, 32'h0, 1'b0), 3);
    run_op("SH", 4'd7, 32'h102, 32'h1234ABCD, 32'h0BADF00D, 32'h0, 0,
           mk_res(5'd7, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b1, 4'b0011, 32'h100, 32'hABCDABCD, 1'b1), 2);
    run_op("SB", 4'd6, 32'h101, 32'h0000005A, 32'h0BADF00D, 32'h0, 0,
           mk_res(5'd8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b1, 4'b0100, 32'h100, 32'h5A5A5A5A, 1'b1), 2);
    run_op("SW", 4'd8, 32'h108, 32'hCAFEF00D, 32'h0BADF00D, 32'h0, 1,
           mk_res(5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b1, 4'b1111, 32'h108, 32'hCAFEF00D, 1'b1), 3);
    run_op("LW_misaligned", 4'd5, 32'h101, 32'h0, 32'h0BADF00D, 32'h0, 0,
           mk_res(5'd10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, nb, 0);
    run_op("SH_misaligned", 4'd7, 32'h101, 32'h0, 32'h0BADF00D, 32'h0, 0,
           mk_res(5'd11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, nb, 0);
    run_op("LH_misaligned", 4'd3, 32'h103, 32'h0, 32'h0BADF00D, 32'h0, 0,
           mk_res(5'd12, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, nb, 0);
    run_op("NOP", 4'd0, 32'h101, 32'h0, 32'h13579BDF, 32'h0, 0,
           mk_res(5'd13, 1'b1, 32'h13579BDF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, nb, 0);
    run_op("OP13", 4'd13, 32'h0, 32'h0, 32'h2468ACE0, 32'h0, 0,
           mk_res(5'd14, 1'b1, 32'h2468ACE0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, nb, 0);

    // LL then SC with a forwarded LLbit of 1, then SC with LLbit 0
    run_op("LL", 4'd9, 32'h200, 32'h0, 32'h0BADF00D, 32'h11223344, 0,
           mk_res(5'd15, 1'b1, 32'h11223344, 1'b1, LLSC, LLSC, 1'b0, 1'b0),
           1'b1, mk_bus(1'b0, 4'b1111, 32'h200, 32'h0, 1'b0), 2);
    LLbit_i = 1'b0; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    run_op("SC_ok", 4'd10, 32'h200, 32'hCAFEBABE, 32'h0BADF00D, 32'h0, 0,
           mk_res(5'd16, 1'b1, 32'h1, 1'b1, LLSC, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b1, 4'b1111, 32'h200, 32'hCAFEBABE, 1'b1), 2);
    wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
`ifdef LLSC_EN
    run_op("SC_fail", 4'd10, 32'h200, 32'hCAFEBABE, 32'h0BADF00D, 32'h0, 0,
           mk_res(5'd16, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, nb, 0);
`else
    run_op("SC_as_SW", 4'd10, 32'h200, 32'hCAFEBABE, 32'h0BADF00D, 32'h0, 0,
           mk_res(5'd16, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b1, 4'b1111, 32'h200, 32'hCAFEBABE, 1'b1), 2);
`endif

    // Flush during REQ: drain until ack with no register write
    @(posedge clk); #1;
    ex_memop = 4'd5; ex_mem_addr = 32'h300; ex_wreg = 1'b1; ex_wd = 5'd3;
    ack_delay = 3; bus_rdata_v = 32'h55555555;
    bus_q.push_back(mk_bus(1'b0, 4'b1111, 32'h300, 32'h0, 1'b0)); bus_name_q.push_back("LW_flush");
    @(posedge clk); #1;
    check("flush bus_req rise", 80'(bus_req), 80'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; ex_memop = 4'd0; ex_wdata = 32'h00000077; ex_wd = 5'd3; ex_wreg = 1'b1;
    res_q.push_back(mk_res(5'd3, 1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    res_name_q.push_back("after_drain");
    op_valid = 1'b1;
    stalls = 0; wreg_seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!stallreq) done = 1'b1;
      else begin stalls++; if (mem_wreg) wreg_seen = 1'b1; end
    end
    check("drain stall", 80'(stalls), 80'(3));
    check("drain wreg", 80'(wreg_seen), 80'(0));
    @(posedge clk); #1;
    op_valid = 1'b0; ex_wreg = 1'b0;

    // Asynchronous reset in the middle of REQ
    @(posedge clk); #1;
    ex_memop = 4'd5; ex_mem_addr = 32'h400; ex_wreg = 1'b1; ex_wd = 5'd8;
    ex_wdata = 32'hFFFFFFFF; ack_delay = 1000;
    @(posedge clk); #1;
    check("rst bus_req before", 80'(bus_req), 80'(1));
    #2; rst = 1'b0; #1;
    check("rst bus_req async", 80'(bus_req), 80'(0));
    check("rst outputs async", 80'({mem_wd, mem_wreg, mem_wdata, mem_LLbit_we, mem_LLbit_value,
                                    stallreq, adel, ades, bus_we, bus_sel}), 80'(0));
    @(posedge clk); #1;
    check("rst bus_req held", 80'(bus_req), 80'(0));
    ex_memop = 4'd0; ex_wreg = 1'b0;
    @(negedge clk); rst = 1'b1;
    run_op("LW_after_rst", 4'd5, 32'h404, 32'h0, 32'h0BADF00D, 32'h87654321, 0,
           mk_res(5'd17, 1'b1, 32'h87654321, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, mk_bus(1'b0, 4'b1111, 32'h404, 32'h0, 1'b0), 2);

    repeat (2) @(posedge clk);
    check("result queue drained", 80'(res_q.size()), 80'(0));
    check("bus queue drained", 80'(bus_q.size()), 80'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
